// File: rtl/keypad_bcd_loader.sv
// Keypad front end for the microwave timer: debounces the 10-key pad,
// accepts one key at a time and presents it as a BCD digit with a
// single-cycle load strobe. At most three digits are accepted per clear.
module keypad_bcd_loader #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  input  logic [9:0] keypad,
  output logic [3:0] bcd_output,
  output logic       load,
  output logic [1:0] digit_count,
  output logic       full
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    EMIT,
    WAIT_RELEASE
  } state_t;

  localparam logic [7:0] LAST_SAMPLE = 8'(DEBOUNCE_CYCLES);

  state_t      state_q, state_d;
  logic [9:0]  pattern_q, pattern_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        load_q, load_d;
  logic [3:0]  bcd_q, bcd_d;
  logic [1:0]  count_q, count_d;

  // Index of the single set bit; the caller guarantees a one-hot pattern.
  function automatic logic [3:0] encode(input logic [9:0] pat);
    logic [3:0] idx;
    idx = 4'd0;
    for (int n = 0; n < 10; n++) begin
      if (pat[n]) idx = 4'(n);
    end
    return idx;
  endfunction

  // Digit count stops at three.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  // Sample counter never wraps.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign cnt_inc     = sat_inc8(cnt_q);
  assign full        = (count_q == 2'd3);
  assign load        = load_q;
  assign bcd_output  = bcd_q;
  assign digit_count = count_q;

  // Next-state and datapath decode; load is only ever raised on the
  // debounce-complete transition so it is high for exactly one cycle.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    load_d    = 1'b0;
    bcd_d     = bcd_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (enable && !full && $onehot(keypad)) begin
          pattern_d = keypad;
          cnt_d     = 8'd1;
          state_d   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if ((keypad != pattern_q) || !enable) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == LAST_SAMPLE) begin
            state_d = EMIT;
            load_d  = 1'b1;
            bcd_d   = encode(pattern_q);
          end
        end
      end
      EMIT: begin
        count_d = sat_inc2(count_q);
        cnt_d   = 8'd0;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (keypad == 10'd0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LAST_SAMPLE) begin
            cnt_d   = 8'd0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = 8'd0;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = WAIT_RELEASE;
      end
    endcase
  end

  // State register; clear lands in WAIT_RELEASE so a key held across
  // clear must be released before anything new is accepted.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= WAIT_RELEASE;
      pattern_q <= 10'd0;
      cnt_q     <= 8'd0;
      load_q    <= 1'b0;
      bcd_q     <= 4'd0;
      count_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      bcd_q     <= bcd_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_keypad_bcd_loader.sv
// Bench for keypad_bcd_loader: a directed vector table, directed corner
// sequences, and a randomized run against a behavioural model.
module tb_keypad_bcd_loader;

  localparam int D = 4;

  logic       clk;
  logic       clear;
  logic       enable;
  logic [9:0] keypad;
  logic [3:0] bcd_output;
  logic       load;
  logic [1:0] digit_count;
  logic       full;

  int errors = 0;
  int checks = 0;
  int loads_seen = 0;

  // Behavioural model state
  bit m_ready;      // keypad has been seen released long enough
  int m_zeros;      // consecutive zero samples while not ready
  int m_run;        // consecutive samples of the held key (0 = none held)
  int m_pat;
  bit m_strobe;     // strobe raised on the previous edge
  int m_load;
  int m_bcd;
  int m_cnt;

  keypad_bcd_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .clear(clear),
    .enable(enable),
    .keypad(keypad),
    .bcd_output(bcd_output),
    .load(load),
    .digit_count(digit_count),
    .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the model, from the plain rules of key entry.
  task automatic model_step(input logic [9:0] kp, input logic en, input logic clr);
    if (clr) begin
      m_ready = 0; m_zeros = 0; m_run = 0; m_strobe = 0;
      m_load = 0; m_bcd = 0; m_cnt = 0; m_pat = 0;
    end else if (m_strobe) begin
      m_strobe = 0;
      m_load = 0;
      if (m_cnt < 3) m_cnt = m_cnt + 1;
      m_ready = 0;
      m_zeros = 0;
    end else if (!m_ready) begin
      m_load = 0;
      if (kp == 0) m_zeros = m_zeros + 1;
      else m_zeros = 0;
      if (m_zeros == D) begin
        m_ready = 1;
        m_run = 0;
      end
    end else begin
      m_load = 0;
      if (m_run == 0) begin
        if (en && m_cnt < 3 && $countones(kp) == 1) begin
          m_pat = int'(kp);
          m_run = 1;
        end
      end else if (int'(kp) != m_pat || !en) begin
        m_run = 0;
      end else begin
        m_run = m_run + 1;
        if (m_run == D) begin
          m_load = 1;
          m_bcd = $clog2(m_pat);
          m_strobe = 1;
          m_run = 0;
        end
      end
    end
  endtask

  task automatic tick(input logic [9:0] kp, input logic en, input logic clr);
    keypad = kp;
    enable = en;
    clear  = clr;
    @(posedge clk);
    #1;
    model_step(kp, en, clr);
    if (load) loads_seen++;
    chk("load", int'(load), m_load);
    chk("bcd_output", int'(bcd_output), m_bcd);
    chk("digit_count", int'(digit_count), m_cnt);
    chk("full", int'(full), (m_cnt == 3) ? 1 : 0);
  endtask

  task automatic hold(input logic [9:0] kp, input logic en, input int n);
    for (int i = 0; i < n; i++) tick(kp, en, 1'b0);
  endtask

  task automatic do_clear();
    tick(10'd0, 1'b1, 1'b1);
    hold(10'd0, 1'b1, D);
  endtask

  typedef struct {
    logic [9:0] kp;
    logic [0:0] ld;
    logic [3:0] bcd;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl[10];
  int   base;

  initial begin
    keypad = 10'd0;
    enable = 1'b1;
    clear  = 1'b1;

    // Clean press of key 5 followed by a full release, expected values by hand
    tbl[0] = '{10'b0000100000, 1'b0, 4'd0, 2'd0};
    tbl[1] = '{10'b0000100000, 1'b0, 4'd0, 2'd0};
    tbl[2] = '{10'b0000100000, 1'b0, 4'd0, 2'd0};
    tbl[3] = '{10'b0000100000, 1'b1, 4'd5, 2'd0};
    tbl[4] = '{10'b0000100000, 1'b0, 4'd5, 2'd1};
    tbl[5] = '{10'b0000000000, 1'b0, 4'd5, 2'd1};
    tbl[6] = '{10'b0000000000, 1'b0, 4'd5, 2'd1};
    tbl[7] = '{10'b0000000000, 1'b0, 4'd5, 2'd1};
    tbl[8] = '{10'b0000000000, 1'b0, 4'd5, 2'd1};
    tbl[9] = '{10'b0000000000, 1'b0, 4'd5, 2'd1};

    // Reset with no keys held
    tick(10'd0, 1'b1, 1'b1);
    chk("reset_load", int'(load), 0);
    chk("reset_bcd", int'(bcd_output), 0);
    chk("reset_count", int'(digit_count), 0);
    chk("reset_full", int'(full), 0);
    hold(10'd0, 1'b1, D);
    chk("reset_no_load", loads_seen, 0);

    // Table-driven clean press
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].kp, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_load", i), int'(load), int'(tbl[i].ld));
      chk($sformatf("tbl%0d_bcd", i), int'(bcd_output), int'(tbl[i].bcd));
      chk($sformatf("tbl%0d_count", i), int'(digit_count), int'(tbl[i].cnt));
    end

    // Bounce: short glitch, gap, then a real press
    base = loads_seen;
    hold(10'b0010000000, 1'b1, 3);
    hold(10'd0, 1'b1, 1);
    hold(10'b0010000000, 1'b1, 6);
    hold(10'd0, 1'b1, D + 1);
    chk("bounce_loads", loads_seen - base, 1);
    chk("bounce_bcd", int'(bcd_output), 7);

    // Two keys at once
    base = loads_seen;
    hold(10'b0000001100, 1'b1, 10);
    hold(10'd0, 1'b1, D + 1);
    chk("multikey_loads", loads_seen - base, 0);

    // Long hold of key 9 gives one digit
    do_clear();
    base = loads_seen;
    hold(10'b1000000000, 1'b1, 40);
    chk("held_loads", loads_seen - base, 1);
    chk("held_bcd", int'(bcd_output), 9);

    // Clear while key 9 stays held, then release and press again
    base = loads_seen;
    tick(10'b1000000000, 1'b1, 1'b1);
    chk("clr_held_count", int'(digit_count), 0);
    hold(10'b1000000000, 1'b1, 12);
    chk("clr_held_loads", loads_seen - base, 0);
    hold(10'd0, 1'b1, D + 1);
    hold(10'b1000000000, 1'b1, 8);
    chk("repress_loads", loads_seen - base, 1);
    hold(10'd0, 1'b1, D + 1);

    // Saturation at three digits
    do_clear();
    base = loads_seen;
    for (int k = 1; k <= 4; k++) begin
      hold(10'(1 << k), 1'b1, 10);
      hold(10'd0, 1'b1, 10);
      if (k == 3) begin
        chk("sat_count3", int'(digit_count), 3);
        chk("sat_full", int'(full), 1);
        chk("sat_bcd3", int'(bcd_output), 3);
      end
    end
    chk("sat_loads", loads_seen - base, 3);
    chk("sat_bcd_kept", int'(bcd_output), 3);
    do_clear();
    base = loads_seen;
    hold(10'b0000010000, 1'b1, 10);
    chk("after_clr_loads", loads_seen - base, 1);
    chk("after_clr_bcd", int'(bcd_output), 4);
    hold(10'd0, 1'b1, D + 1);

    // Enable gating
    do_clear();
    base = loads_seen;
    hold(10'b0001000000, 1'b0, 10);
    hold(10'd0, 1'b1, D + 1);
    chk("en_low_loads", loads_seen - base, 0);
    tick(10'b0001000000, 1'b1, 1'b0);
    tick(10'b0001000000, 1'b1, 1'b0);
    tick(10'b0001000000, 1'b0, 1'b0);
    hold(10'b0001000000, 1'b0, 4);
    hold(10'd0, 1'b1, D + 1);
    chk("en_abort_loads", loads_seen - base, 0);
    chk("en_abort_count", int'(digit_count), 0);

    // Randomized run against the model
    do_clear();
    for (int seg = 0; seg < 400; seg++) begin
      logic [9:0] kp;
      logic       en;
      int         r;
      int         len;
      r = $urandom_range(0, 9);
      if (r <= 2) kp = 10'd0;
      else if (r <= 7) kp = 10'(1 << $urandom_range(0, 9));
      else if (r == 8) kp = 10'(1 << $urandom_range(0, 9)) | 10'(1 << $urandom_range(0, 9));
      else kp = 10'($urandom_range(0, 1023));
      en  = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        tick(kp, en, ($urandom_range(0, 59) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
